// File: rtl/socket_source_if.sv
// Word-side handshake and socket write-side bus of socket_source.
// master: the socket_source block; slave: producer + downstream socket.
interface socket_source_if #(
    parameter int unsigned DATA_WITH = 8,
    parameter int unsigned NB_BYTES  = 4
);
    logic [NB_BYTES*DATA_WITH-1:0] i_word;
    logic                          i_valid;
    logic                          o_ready;
    logic                          i_full;
    logic                          o_wr_en;
    logic [DATA_WITH-1:0]          o_data;
    logic                          o_busy;

    modport master (
        input  i_word, i_valid, i_full,
        output o_ready, o_wr_en, o_data, o_busy
    );

    modport slave (
        output i_word, i_valid, i_full,
        input  o_ready, o_wr_en, o_data, o_busy
    );
endinterface

// File: rtl/socket_source.sv
// socket_source: accepts one NB_BYTES-wide word over valid/ready and writes
// it LSB-byte-first into a socket FIFO, honouring the FIFO full flag.
// Optional feature macro: SOCKET_SOURCE_CKSUM_EN appends one XOR checksum
// byte after every word.
module socket_source #(
    parameter int unsigned DATA_WITH = 8,
    parameter int unsigned NB_BYTES  = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    socket_source_if.master bus
);
    localparam int unsigned WORD_W = NB_BYTES * DATA_WITH;
    localparam int unsigned CNT_W  = $clog2(NB_BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1
`ifdef SOCKET_SOURCE_CKSUM_EN
        ,
        CKSUM = 2'd2
`endif
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [WORD_W-1:0]   shreg;
    logic [CNT_W-1:0]    cnt;
`ifdef SOCKET_SOURCE_CKSUM_EN
    logic [DATA_WITH-1:0] cksum;
`endif

    logic wr_en_c;
    logic last_byte_c;
    logic final_xfer_c;
    logic ready_c;
    logic accept_c;

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept_c) state_nxt = SEND;
            end
            SEND: begin
                if (wr_en_c && last_byte_c) begin
`ifdef SOCKET_SOURCE_CKSUM_EN
                    state_nxt = CKSUM;
`else
                    state_nxt = accept_c ? SEND : IDLE;
`endif
                end
            end
`ifdef SOCKET_SOURCE_CKSUM_EN
            CKSUM: begin
                if (wr_en_c) state_nxt = accept_c ? SEND : IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake, write strobe and output byte; a word's final transfer frees the slot
    always_comb begin
        last_byte_c  = (cnt == CNT_W'(NB_BYTES - 1));
`ifdef SOCKET_SOURCE_CKSUM_EN
        wr_en_c      = ((state == SEND) || (state == CKSUM)) && !bus.i_full && i_rst;
        final_xfer_c = wr_en_c && (state == CKSUM);
        bus.o_data   = (state == CKSUM) ? cksum : shreg[DATA_WITH-1:0];
`else
        wr_en_c      = (state == SEND) && !bus.i_full && i_rst;
        final_xfer_c = wr_en_c && (state == SEND) && last_byte_c;
        bus.o_data   = shreg[DATA_WITH-1:0];
`endif
        ready_c      = i_rst && ((state == IDLE) || final_xfer_c);
        accept_c     = bus.i_valid && ready_c;
        bus.o_wr_en  = wr_en_c;
        bus.o_ready  = ready_c;
        bus.o_busy   = (state != IDLE);
    end

    // Shift register, byte counter and running checksum
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            shreg <= '0;
            cnt   <= '0;
`ifdef SOCKET_SOURCE_CKSUM_EN
            cksum <= '0;
`endif
        end else if (accept_c) begin
            shreg <= bus.i_word;
            cnt   <= '0;
`ifdef SOCKET_SOURCE_CKSUM_EN
            cksum <= '0;
`endif
        end else if (wr_en_c && (state == SEND)) begin
            shreg <= {DATA_WITH'(0), shreg[WORD_W-1:DATA_WITH]};
            cnt   <= CNT_W'(cnt + CNT_W'(1));
`ifdef SOCKET_SOURCE_CKSUM_EN
            cksum <= cksum ^ shreg[DATA_WITH-1:0];
`endif
        end
    end
endmodule

// File: tb/tb_socket_source.sv
// Directed bench for socket_source (default build, NB_BYTES=4, DATA_WITH=8).
module tb_socket_source;
    logic i_clk;
    logic i_rst;
    int   checks;
    int   errors;

    socket_source_if #(.DATA_WITH(8), .NB_BYTES(4)) bus ();

    socket_source #(.DATA_WITH(8), .NB_BYTES(4)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Check all four outputs for the current cycle
    task automatic chk_out(input string tag, input logic wr, input logic [7:0] data,
                           input logic rdy, input logic busy);
        chk({tag, "_wr"},   32'(bus.o_wr_en), 32'(wr));
        chk({tag, "_data"}, 32'(bus.o_data),  32'(data));
        chk({tag, "_rdy"},  32'(bus.o_ready), 32'(rdy));
        chk({tag, "_busy"}, 32'(bus.o_busy),  32'(busy));
    endtask

    // Expect the four bytes of w on consecutive cycles with no stall
    task automatic expect_word(input string tag, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk_out($sformatf("%s_b%0d", tag, k), 1'b1, w[8*k +: 8], (k == 3), 1'b1);
            step();
        end
    endtask

    task automatic accept(input logic [31:0] w);
        bus.i_word  = w;
        bus.i_valid = 1'b1;
        #1;
        chk("acc_rdy", 32'(bus.o_ready), 32'd1);
        step();
        bus.i_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        checks      = 0;
        errors      = 0;
        i_rst       = 1'b0;
        bus.i_word  = '0;
        bus.i_valid = 1'b0;
        bus.i_full  = 1'b0;

        // Reset state
        step();
        step();
        chk_out("rst", 1'b0, 8'h00, 1'b0, 1'b0);
        i_rst = 1'b1;
        #1;
        chk_out("post_rst", 1'b0, 8'h00, 1'b1, 1'b0);
        step();

        // Single word, no backpressure
        accept(32'h44332211);
        expect_word("t1", 32'h44332211);
        #1;
        chk_out("t1_idle", 1'b0, 8'h00, 1'b1, 1'b0);
        step();

        // Backpressure while 0x22 is pending
        accept(32'h44332211);
        #1;
        chk_out("t3_b0", 1'b1, 8'h11, 1'b0, 1'b1);
        step();
        bus.i_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk_out($sformatf("t3_full%0d", k), 1'b0, 8'h22, 1'b0, 1'b1);
            step();
        end
        bus.i_full = 1'b0;
        w = 32'h44332211;
        for (int k = 1; k < 4; k++) begin
            #1;
            chk_out($sformatf("t3_b%0d", k), 1'b1, w[8*k +: 8], (k == 3), 1'b1);
            step();
        end
        #1;
        chk_out("t3_idle", 1'b0, 8'h00, 1'b1, 1'b0);
        step();

        // Back-to-back words, i_valid held high
        bus.i_word  = 32'hDDCCBBAA;
        bus.i_valid = 1'b1;
        step();
        bus.i_word = 32'h04030201;
        for (int k = 0; k < 8; k++) begin
            logic [63:0] pair;
            pair = 64'h04030201_DDCCBBAA;
            #1;
            chk_out($sformatf("t4_b%0d", k), 1'b1, pair[8*k +: 8], (k == 3) || (k == 7), 1'b1);
            step();
            if (k == 3) bus.i_valid = 1'b0;
        end
        #1;
        chk_out("t4_idle", 1'b0, 8'h00, 1'b1, 1'b0);
        step();

        // Reset mid-word after two bytes
        accept(32'h44332211);
        #1;
        chk_out("t5_b0", 1'b1, 8'h11, 1'b0, 1'b1);
        step();
        #1;
        chk_out("t5_b1", 1'b1, 8'h22, 1'b0, 1'b1);
        step();
        i_rst = 1'b0;
        #1;
        chk_out("t5_rst", 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        step();
        i_rst = 1'b1;
        #1;
        chk_out("t5_rel", 1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            #1;
            chk($sformatf("t5_quiet%0d_wr", k), 32'(bus.o_wr_en), 32'd0);
        end
        step();

        // New word presented (and changed) while busy is ignored until o_ready
        accept(32'h44332211);
        bus.i_valid = 1'b1;
        bus.i_word  = 32'hDEADBEEF;
        w = 32'h44332211;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk_out($sformatf("t6_b%0d", k), 1'b1, w[8*k +: 8], (k == 3), 1'b1);
            step();
            if (k == 1) bus.i_word = 32'h88776655;
        end
        bus.i_valid = 1'b0;
        expect_word("t6_new", 32'h88776655);
        #1;
        chk_out("t6_idle", 1'b0, 8'h00, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
